// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with lookahead fetch coordinates
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int LOOKAHEAD = 2,
   parameter int CNT_W     = 10
) (
   input  logic             clk_50mhz,
   input  logic             reset,
   input  logic             clk_enable,
   output logic             hsync,
   output logic             vsync,
   output logic             display_enable,
   output logic [CNT_W-1:0] pixel_x,
   output logic [CNT_W-1:0] pixel_y,
   output logic             fetch_valid,
   output logic [CNT_W-1:0] fetch_x,
   output logic [CNT_W-1:0] fetch_y,
   output logic             line_start,
   output logic             frame_start,
   output logic             vblank_start,
   output logic [15:0]      frame_count
);
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Comparisons are done one bit wider so sums and sync end points never truncate.
   localparam logic [CNT_W:0]   C_H_TOTAL = (CNT_W+1)'(H_TOTAL);
   localparam logic [CNT_W:0]   C_LOOK    = (CNT_W+1)'(LOOKAHEAD);
   localparam logic [CNT_W:0]   C_H_VIS   = (CNT_W+1)'(H_VISIBLE);
   localparam logic [CNT_W:0]   C_V_VIS   = (CNT_W+1)'(V_VISIBLE);
   localparam logic [CNT_W:0]   C_HS_BEG  = (CNT_W+1)'(H_VISIBLE + H_FRONT);
   localparam logic [CNT_W:0]   C_HS_END  = (CNT_W+1)'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [CNT_W:0]   C_VS_BEG  = (CNT_W+1)'(V_VISIBLE + V_FRONT);
   localparam logic [CNT_W:0]   C_VS_END  = (CNT_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [CNT_W-1:0] C_H_LAST  = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] C_V_LAST  = CNT_W'(V_TOTAL - 1);

   logic [CNT_W-1:0] r_h, r_v;
   logic             r_first;

   logic [CNT_W:0]   w_h_ext, w_v_ext, w_fh_sum;
   logic             w_fh_over, w_v_last, w_h_last;
   logic [CNT_W-1:0] w_fh, w_fv;
   logic             w_de, w_hs_act, w_vs_act, w_fvalid;

   always_comb begin
      w_h_ext   = {1'b0, r_h};
      w_v_ext   = {1'b0, r_v};
      w_h_last  = (r_h == C_H_LAST);
      w_v_last  = (r_v == C_V_LAST);
      w_fh_sum  = w_h_ext + C_LOOK;
      w_fh_over = (w_fh_sum >= C_H_TOTAL);
      w_fh      = w_fh_over ? CNT_W'(w_fh_sum - C_H_TOTAL) : CNT_W'(w_fh_sum);
      w_fv      = w_fh_over ? (w_v_last ? '0 : r_v + 1'b1) : r_v;
      w_de      = (w_h_ext < C_H_VIS) && (w_v_ext < C_V_VIS);
      w_hs_act  = (w_h_ext >= C_HS_BEG) && (w_h_ext < C_HS_END);
      w_vs_act  = (w_v_ext >= C_VS_BEG) && (w_v_ext < C_VS_END);
      w_fvalid  = ({1'b0, w_fh} < C_H_VIS) && ({1'b0, w_fv} < C_V_VIS);
   end

   always_ff @(posedge clk_50mhz) begin
      if (reset) begin
         r_h            <= '0;
         r_v            <= '0;
         r_first        <= 1'b1;
         hsync          <= ~HSYNC_POL;
         vsync          <= ~VSYNC_POL;
         display_enable <= 1'b0;
         pixel_x        <= '0;
         pixel_y        <= '0;
         fetch_valid    <= 1'b0;
         fetch_x        <= '0;
         fetch_y        <= '0;
         line_start     <= 1'b0;
         frame_start    <= 1'b0;
         vblank_start   <= 1'b0;
         frame_count    <= '0;
      end else begin
         line_start   <= 1'b0;
         frame_start  <= 1'b0;
         vblank_start <= 1'b0;
         if (clk_enable) begin
            pixel_x        <= r_h;
            pixel_y        <= r_v;
            display_enable <= w_de;
            hsync          <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
            vsync          <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
            fetch_x        <= w_fh;
            fetch_y        <= w_fv;
            fetch_valid    <= w_fvalid;
            line_start     <= (r_h == '0);
            frame_start    <= (r_h == '0) && (r_v == '0);
            vblank_start   <= (r_h == '0) && (w_v_ext == C_V_VIS);
            // The frame entered straight out of reset is not a completed frame.
            if ((r_h == '0) && (r_v == '0)) begin
               if (r_first) r_first <= 1'b0;
               else         frame_count <= frame_count + 16'd1;
            end
            r_h <= w_h_last ? '0 : r_h + 1'b1;
            if (w_h_last) r_v <= w_v_last ? '0 : r_v + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized bench comparing vga_timing_gen against a raster position model
module tb_vga_timing_gen;
   localparam int HV = 8, HF = 1, HS = 2, HB = 1;
   localparam int VV = 4, VF = 1, VS = 1, VB = 1;
   localparam bit HPOL = 1'b1, VPOL = 1'b0;
   localparam int LA = 5, CW = 4;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FR = HT * VT;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic clk_enable = 1'b0;
   logic hsync, vsync, display_enable, fetch_valid;
   logic line_start, frame_start, vblank_start;
   logic [CW-1:0] pixel_x, pixel_y, fetch_x, fetch_y;
   logic [15:0] frame_count;

   int n_checks = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .LOOKAHEAD(LA), .CNT_W(CW)
   ) dut (
      .clk_50mhz(clk), .reset(reset), .clk_enable(clk_enable),
      .hsync(hsync), .vsync(vsync), .display_enable(display_enable),
      .pixel_x(pixel_x), .pixel_y(pixel_y),
      .fetch_valid(fetch_valid), .fetch_x(fetch_x), .fetch_y(fetch_y),
      .line_start(line_start), .frame_start(frame_start), .vblank_start(vblank_start),
      .frame_count(frame_count)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the raster is just a linear pixel index; everything derives from it with div/mod.
   int pos = 0;
   int e_px = 0, e_py = 0, e_de = 0, e_hs = !HPOL, e_vs = !VPOL;
   int e_fx = 0, e_fy = 0, e_fv = 0, e_ls = 0, e_fs = 0, e_vb = 0, e_fc = 0;
   int pulses = 0, ls_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_num = 0;
   bit fs_seen = 0, after_reset = 0;

   always @(posedge clk) begin
      bit r, en;
      int h, v, f;
      r  = reset;
      en = clk_enable;
      #1;
      if (r) begin
         pos = 0;
         e_px = 0; e_py = 0; e_de = 0; e_hs = !HPOL; e_vs = !VPOL;
         e_fx = 0; e_fy = 0; e_fv = 0; e_ls = 0; e_fs = 0; e_vb = 0; e_fc = 0;
         fs_seen = 0; fs_num = 0; after_reset = 1;
      end else if (en) begin
         h = pos % HT;
         v = (pos / HT) % VT;
         f = (pos + LA) % FR;
         e_px = h; e_py = v;
         e_de = (h < HV && v < VV);
         e_hs = (h >= HV + HF && h < HV + HF + HS) ? HPOL : !HPOL;
         e_vs = (v >= VV + VF && v < VV + VF + VS) ? VPOL : !VPOL;
         e_fx = f % HT; e_fy = f / HT;
         e_fv = (e_fx < HV && e_fy < VV);
         e_ls = (h == 0); e_fs = (h == 0 && v == 0); e_vb = (h == 0 && v == VV);
         e_fc = (pos / FR) % 65536;
         pos++;
      end else begin
         e_ls = 0; e_fs = 0; e_vb = 0;
      end

      chk("pixel_x", pixel_x, e_px);
      chk("pixel_y", pixel_y, e_py);
      chk("display_enable", display_enable, e_de);
      chk("hsync", hsync, e_hs);
      chk("vsync", vsync, e_vs);
      chk("fetch_x", fetch_x, e_fx);
      chk("fetch_y", fetch_y, e_fy);
      chk("fetch_valid", fetch_valid, e_fv);
      chk("line_start", line_start, e_ls);
      chk("frame_start", frame_start, e_fs);
      chk("vblank_start", vblank_start, e_vb);
      chk("frame_count", frame_count, e_fc);

      // Hand-computed pins for this 12x7 raster with LOOKAHEAD=5.
      if (!r && en) begin
         if (after_reset) begin
            chk("post_reset_x", pixel_x, 0);
            chk("post_reset_y", pixel_y, 0);
            chk("post_reset_de", display_enable, 1);
            chk("post_reset_fs", frame_start, 1);
            chk("post_reset_fc", frame_count, 0);
            after_reset = 0;
         end
         if (pixel_x == 11 && pixel_y == 2) begin
            chk("lit_fetch_x_wrap", fetch_x, 4);
            chk("lit_fetch_y_wrap", fetch_y, 3);
            chk("lit_fetch_valid_wrap", fetch_valid, 1);
         end
         if (pixel_x == 11 && pixel_y == 6) begin
            chk("lit_fetch_x_frame", fetch_x, 4);
            chk("lit_fetch_y_frame", fetch_y, 0);
            chk("lit_fetch_valid_frame", fetch_valid, 1);
         end
         if (pixel_x == 9 || pixel_x == 10) chk("lit_hsync_high", hsync, 1);
         if (frame_start) begin
            if (fs_seen) begin
               chk("lit_frame_pulses", pulses, 84);
               chk("lit_lines_per_frame", ls_cnt, 7);
               chk("lit_hsync_pulses", hs_cnt, 14);
               chk("lit_vsync_pulses", vs_cnt, 12);
            end
            chk("lit_frame_count_seq", frame_count, fs_num);
            fs_num++;
            fs_seen = 1;
            pulses = 0; ls_cnt = 0; hs_cnt = 0; vs_cnt = 0;
         end
         pulses++;
         ls_cnt += int'(line_start);
         hs_cnt += int'(hsync);
         vs_cnt += int'(!vsync);
      end
   end

   task automatic pulse_after_gap(input int gap);
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         clk_enable = 1'b0;
      end
      @(negedge clk);
      clk_enable = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      // Enable every second clock for a little over three frames.
      for (int i = 0; i < 3 * FR * 2 + 10; i++) begin
         @(negedge clk);
         clk_enable = (i % 2 == 1);
      end
      // Random idle gaps between pixels.
      for (int i = 0; i < 300; i++) pulse_after_gap($urandom_range(0, 5));
      // Reset mid-frame for 3 clocks, with enable high on one of them.
      for (int i = 0; i < 40; i++) pulse_after_gap($urandom_range(0, 2));
      @(negedge clk);
      reset = 1'b1;
      clk_enable = 1'b1;
      @(negedge clk);
      clk_enable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 200; i++) pulse_after_gap($urandom_range(0, 5));
      // Back-to-back enables.
      for (int i = 0; i < 3 * FR; i++) pulse_after_gap(0);
      @(negedge clk);
      clk_enable = 1'b0;
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
